// File: rtl/div2048by1024.sv
// div2048by1024: bit-serial restoring divider, DW-bit dividend by VW-bit divisor.
// Latency: DW cycles load->valid (DW+2 with DIV_SIGNED_EN); 1 cycle on divide-by-zero.
// Backpressure: none; iLoad is ignored while oBusy, result held in DONE until reload.
//
// Ports:
//   iClk, iRstn   clock, asynchronous active-low reset
//   iEnable       synchronous clear (0 = force IDLE, clear everything)
//   iLoad, iX, iY start strobe with dividend/divisor, sampled on the same edge
//   oBusy         operation in progress
//   oDataValid    oQ/oR valid (level, held in DONE)
//   oDivByZero    last operation had iY==0
//   oQ, oR        quotient / remainder, zero unless oDataValid
// Build option: define DIV_SIGNED_EN for two's complement operands (adds ABS/FIX).

module div2048by1024 #(
   parameter int DW = 2048,
   parameter int VW = 1024
) (
   input  logic          iClk,
   input  logic          iRstn,
   input  logic          iEnable,
   input  logic          iLoad,
   input  logic [DW-1:0] iX,
   input  logic [VW-1:0] iY,
   output logic          oBusy,
   output logic          oDataValid,
   output logic          oDivByZero,
   output logic [DW-1:0] oQ,
   output logic [VW-1:0] oR
);

   localparam int CW = 12;

   // ABS and FIX are unreachable in the unsigned build and drop out of synthesis.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ABS  = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t        state, nextState;
   logic [DW-1:0] q;          // dividend shifting out, quotient shifting in
   logic [VW:0]   p;          // partial remainder
   logic [VW-1:0] d;          // divisor
   logic [CW-1:0] cnt;
   logic          divByZero;
`ifdef DIV_SIGNED_EN
   logic          sq;         // quotient sign
   logic          sr;         // remainder sign (follows dividend)
`endif

   logic          loadOk;
   logic [VW+1:0] diff;
   logic          ge;

   assign loadOk = iLoad & ((state == IDLE) | (state == DONE));

   // One subtractor does both jobs: T - D with an extra guard bit, whose borrow
   // is the T < D compare. p[VW] is always 0 during RUN, so {p, q[DW-1]} == T.
   always_comb begin
      diff = {p, q[DW-1]} - {2'b00, d};
      ge   = ~diff[VW+1];
   end

   // ---------------- state register ----------------
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) state <= IDLE;
      else        state <= nextState;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      nextState = state;
      if (!iEnable) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (iLoad) begin
                  if (iY == '0) nextState = DONE;
`ifdef DIV_SIGNED_EN
                  else          nextState = ABS;
`else
                  else          nextState = RUN;
`endif
               end
            end
            ABS: nextState = RUN;
            RUN: begin
               if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
                  nextState = FIX;
`else
                  nextState = DONE;
`endif
               end
            end
            FIX:     nextState = DONE;
            default: nextState = IDLE;
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         q         <= '0;
         p         <= '0;
         d         <= '0;
         cnt       <= '0;
         divByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
         sq        <= 1'b0;
         sr        <= 1'b0;
`endif
      end else if (!iEnable) begin
         q         <= '0;
         p         <= '0;
         d         <= '0;
         cnt       <= '0;
         divByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
         sq        <= 1'b0;
         sr        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (loadOk) begin
                  d   <= iY;
                  cnt <= CW'(DW - 1);
                  if (iY == '0) begin
                     // Divide-by-zero result is parked directly in Q/P for DONE.
                     q         <= '1;
                     p         <= {1'b0, iX[VW-1:0]};
                     divByZero <= 1'b1;
                  end else begin
                     q         <= iX;
                     p         <= '0;
                     divByZero <= 1'b0;
                  end
               end
            end
`ifdef DIV_SIGNED_EN
            ABS: begin
               sq <= q[DW-1] ^ d[VW-1];
               sr <= q[DW-1];
               // Magnitudes of the most negative values still fit as unsigned.
               if (q[DW-1]) q <= -q;
               if (d[VW-1]) d <= -d;
            end
            FIX: begin
               if (sq) q <= -q;
               if (sr) p <= -p;
            end
`endif
            RUN: begin
               q   <= {q[DW-2:0], ge};
               p   <= ge ? diff[VW:0] : {p[VW-1:0], q[DW-1]};
               cnt <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      oBusy      = (state == ABS) | (state == RUN) | (state == FIX);
      oDataValid = (state == DONE);
      oDivByZero = divByZero;
      oQ         = oDataValid ? q : '0;
      oR         = oDataValid ? p[VW-1:0] : '0;
   end

endmodule
